ff_excitation_gen: RTL and testbench
====================================

Name: ff_excitation_gen

Overview:
- Driver side of the flip-flop excitation interface.
- Accepts a stream of desired next-state bits for a downstream flip-flop and generates that flop's excitation inputs (S/R, J/K, T or D).
- Tracks the flop's predicted state internally and, optionally, checks the flop's fed-back q.
- Sits in front of the team's SR/JK/T/D flop models and their converted variants. It is the encoder counterpart of the excitation-to-state logic those modules implement.

Parameters:
DEPTH, 4, target-bit buffer depth in entries; power of 2, minimum 2.
CNT_W, 8, width of the mismatch error counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  2  flop type: 00 SR, 01 JK, 10 T, 11 D
exc_en  input  1  pop/issue enable
tgt_valid  input  1  target bit offered
tgt_bit  input  1  desired next q
tgt_ready  output  1  buffer can accept
exc_a  output  1  S / J / T / D
exc_b  output  1  R / K; 0 in T and D modes
q_fb  input  1  downstream flop q
busy  output  1  buffer non-empty or check pipeline occupied
mismatch  output  1  one-cycle pulse, q_fb differs from expected
err_cnt  output  CNT_W  saturating mismatch count

Behaviour:
- Interface: one clock, clk; reset asynchronous, active-low, rst_n.
- Reset values:
  - exc_a=0, exc_b=0, tgt_ready=1, busy=0, mismatch=0, err_cnt=0.
  - Buffer empty, q_model=0, active_mode=SR (00), check pipeline invalid.
- Handshake and buffer:
  - tgt_ready = !full, combinational from registered count.
  - Push occurs when tgt_valid and tgt_ready at a rising edge.
  - Push while full is not accepted, even if a pop happens in the same cycle.
  - Buffer is FIFO with no bypass. A bit pushed into an empty buffer is popped no earlier than the next edge.
- Mode:
  - active_mode loads from mode only on edges where the buffer is empty and the check pipeline is empty.
  - A mode change while busy is ignored until idle.
- Issue:
  - At each edge with exc_en=1 and buffer non-empty, pop bit b.
  - exc_a/exc_b are registered from (q_model, b, active_mode). Then q_model <= b.
  - SR/JK encoding:
    - 0->1 gives a=1, b=0.
    - 1->0 gives a=0, b=1.
    - Hold gives a=0, b=0.
    - a=b=1 is never driven.
  - T mode: a = q_model ^ b, b=0.
  - D mode: a = b, b=0.
- Idle (no pop at an edge): exc_a/exc_b <= hold encoding for q_model.
  - SR/JK/T: 0,0.
  - D: a = q_model.
- Latency:
  - Push at edge N, popped at edge N+1 at the earliest.
  - Excitation is visible after N+1.
  - Downstream flop updates at N+2.
  - q_fb is checked at edge N+3.
- Check pipeline: 2-stage expected-value/valid shift register fed by each pop. Stage-2 valid compares q_fb against expected at that edge.
- busy = count!=0 or any check stage valid.
- Back-to-back pops with exc_en held high give one target per cycle, with full throughput.
- Reset mid-operation: buffer, pipeline, q_model, and counter clear immediately; outputs return to their reset values asynchronously.

Optional Feature:
- Macro FF_EXC_FB_CHECK_EN.
- Defined: check pipeline, mismatch pulse, and err_cnt are active. err_cnt increments on each mismatch and saturates at all-ones.
- Undefined:
  - No check pipeline.
  - mismatch tied 0, err_cnt tied 0.
  - q_fb unused.
  - busy = count!=0.

Test Plan:
- SR mode, exc_en=1, push 1,1,0,0,1 -> exc_a/exc_b sequence (1,0),(0,0),(0,1),(0,0),(1,0) on consecutive cycles; with a real SR flop on q_fb, mismatch never pulses.
- T mode, push 1,0,1,1 -> exc_a = 1,1,1,0; exc_b stays 0; err_cnt stays 0 with a T flop attached.
- Fill: exc_en=0, push 5 bits at DEPTH=4 -> tgt_ready drops after 4th accept, 5th held; exc_en=1 -> 5th accepted one cycle after first pop.
- Mismatch: D mode, q_fb forced 0, push 1 -> mismatch pulses once, 3 edges after issue; err_cnt=1. Repeat 260 times at CNT_W=8 -> err_cnt saturates at 255.
- Mode change while busy (JK->D with 2 entries queued) -> entries still encoded JK; D takes effect once busy=0.
- Assert rst_n low mid-stream with 3 entries queued -> tgt_ready=1, exc_a=exc_b=0, err_cnt=0 immediately; subsequent push 1 in SR mode produces (1,0).

Source files
------------

// File: rtl/ff_excitation_gen.sv
// Excitation encoder for SR/JK/T/D flops: buffers desired next-state bits and drives S/R, J/K, T or D.
// Define FF_EXC_FB_CHECK_EN to enable the q_fb check pipeline, mismatch pulse and err_cnt.
module ff_excitation_gen #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             exc_en,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             exc_a,
  output logic             exc_b,
  input  logic             q_fb,
  output logic             busy,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_T  = 2'b10,
    MODE_D  = 2'b11
  } mode_e;

  logic          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          q_model_q, q_model_d;
  mode_e         active_mode_q, active_mode_d;
  logic          exc_a_q, exc_a_d;
  logic          exc_b_q, exc_b_d;

  logic full, empty, push, pop, head_bit, pipe_busy, idle;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign push      = tgt_valid && !full;
  assign pop       = exc_en && !empty;
  assign head_bit  = mem_q[rd_ptr_q];
  assign idle      = empty && !pipe_busy;
  assign tgt_ready = !full;
  assign busy      = !empty || pipe_busy;
  assign exc_a     = exc_a_q;
  assign exc_b     = exc_b_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tgt_bit;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Mode is only sampled when nothing is queued or in flight, so every
  // issued bit is encoded and checked under one consistent flop type.
  always_comb begin
    active_mode_d = active_mode_q;
    if (idle) begin
      active_mode_d = mode_e'(mode);
    end
  end

  always_comb begin
    exc_a_d   = 1'b0;
    exc_b_d   = 1'b0;
    q_model_d = q_model_q;
    if (pop) begin
      q_model_d = head_bit;
      case (active_mode_q)
        MODE_SR, MODE_JK: begin
          exc_a_d = !q_model_q && head_bit;
          exc_b_d = q_model_q && !head_bit;
        end
        MODE_T:  exc_a_d = q_model_q ^ head_bit;
        MODE_D:  exc_a_d = head_bit;
        default: exc_a_d = 1'b0;
      endcase
    end else if (active_mode_q == MODE_D) begin
      exc_a_d = q_model_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      q_model_q     <= 1'b0;
      active_mode_q <= MODE_SR;
      exc_a_q       <= 1'b0;
      exc_b_q       <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      q_model_q     <= q_model_d;
      active_mode_q <= active_mode_d;
      exc_a_q       <= exc_a_d;
      exc_b_q       <= exc_b_d;
    end
  end

`ifdef FF_EXC_FB_CHECK_EN
  // Stage 0 is loaded at the pop edge; stage 1 lines up with the edge
  // after the downstream flop has taken the excitation.
  logic [1:0]       chk_vld_q, chk_vld_d;
  logic [1:0]       chk_exp_q, chk_exp_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign pipe_busy = |chk_vld_q;
  assign mismatch  = mismatch_q;
  assign err_cnt   = err_cnt_q;

  always_comb begin
    chk_vld_d  = {chk_vld_q[0], pop};
    chk_exp_d  = {chk_exp_q[0], head_bit};
    mismatch_d = chk_vld_q[1] && (q_fb != chk_exp_q[1]);
    err_cnt_d  = err_cnt_q;
    if (mismatch_d && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_vld_q  <= '0;
      chk_exp_q  <= '0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      chk_vld_q  <= chk_vld_d;
      chk_exp_q  <= chk_exp_d;
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
    end
  end
`else
  logic unused_q_fb;

  assign unused_q_fb = q_fb;
  assign pipe_busy   = 1'b0;
  assign mismatch    = 1'b0;
  assign err_cnt     = '0;
`endif

endmodule

// File: tb/tb_ff_excitation_gen.sv
// Directed bench for ff_excitation_gen with a behavioural downstream flop on q_fb.
// Expectations for mismatch/err_cnt follow whether FF_EXC_FB_CHECK_EN is defined.
module tb_ff_excitation_gen;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
`ifdef FF_EXC_FB_CHECK_EN
  localparam bit FB_CHK = 1'b1;
`else
  localparam bit FB_CHK = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [1:0]       mode;
  logic             exc_en;
  logic             tgt_valid;
  logic             tgt_bit;
  logic             tgt_ready;
  logic             exc_a;
  logic             exc_b;
  logic             q_fb;
  logic             busy;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;

  logic [1:0] flop_type;
  logic       force_zero;
  logic       q_flop;
  int         n_checks;
  int         n_errors;
  int         mm_pulses;

  ff_excitation_gen #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .exc_en(exc_en),
    .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(tgt_ready),
    .exc_a(exc_a), .exc_b(exc_b), .q_fb(q_fb), .busy(busy),
    .mismatch(mismatch), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream flop of the selected type, driven by the DUT excitation.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_flop <= 1'b0;
    end else begin
      case (flop_type)
        2'b00: if (exc_a) q_flop <= 1'b1; else if (exc_b) q_flop <= 1'b0;
        2'b01: case ({exc_a, exc_b})
                 2'b10:   q_flop <= 1'b1;
                 2'b01:   q_flop <= 1'b0;
                 2'b11:   q_flop <= ~q_flop;
                 default: q_flop <= q_flop;
               endcase
        2'b10: q_flop <= q_flop ^ exc_a;
        default: q_flop <= exc_a;
      endcase
    end
  end
  assign q_fb = force_zero ? 1'b0 : q_flop;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mismatch === 1'b1) mm_pulses++;
  endtask

  task automatic reset_dut(input logic [1:0] m);
    rst_n      = 1'b0;
    tgt_valid  = 1'b0;
    tgt_bit    = 1'b0;
    exc_en     = 1'b0;
    mode       = m;
    flop_type  = m;
    force_zero = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    mm_pulses = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, busy, 0);
  endtask

  logic [0:4] sr_bits, sr_a, sr_b;
  logic [0:3] t_bits, t_a;
  logic [0:3] fill_bits;

  initial begin
    n_checks = 0; n_errors = 0; mm_pulses = 0;
    rst_n = 1'b0; mode = 2'b00; exc_en = 1'b0; tgt_valid = 1'b0; tgt_bit = 1'b0;
    flop_type = 2'b00; force_zero = 1'b0;
    #2;
    check_eq("rst tgt_ready", tgt_ready, 1);
    check_eq("rst exc_a", exc_a, 0);
    check_eq("rst exc_b", exc_b, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst mismatch", mismatch, 0);
    check_eq("rst err_cnt", err_cnt, 0);

    // SR stream: 1,1,0,0,1 from q=0
    reset_dut(2'b00);
    sr_bits = 5'b11001; sr_a = 5'b10001; sr_b = 5'b00100;
    exc_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tgt_valid = 1'b1; tgt_bit = sr_bits[i];
      tick();
      if (i > 0) begin
        check_eq($sformatf("sr a%0d", i - 1), exc_a, sr_a[i-1]);
        check_eq($sformatf("sr b%0d", i - 1), exc_b, sr_b[i-1]);
      end
    end
    tgt_valid = 1'b0;
    tick();
    check_eq("sr a4", exc_a, sr_a[4]);
    check_eq("sr b4", exc_b, sr_b[4]);
    wait_idle("sr drain busy");
    check_eq("sr no mismatch", mm_pulses, 0);

    // T stream: 1,0,1,1 from q=0
    reset_dut(2'b10);
    t_bits = 4'b1011; t_a = 4'b1110;
    exc_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tgt_valid = 1'b1; tgt_bit = t_bits[i];
      tick();
      if (i > 0) begin
        check_eq($sformatf("t a%0d", i - 1), exc_a, t_a[i-1]);
        check_eq($sformatf("t b%0d", i - 1), exc_b, 0);
      end
    end
    tgt_valid = 1'b0;
    tick();
    check_eq("t a3", exc_a, t_a[3]);
    check_eq("t b3", exc_b, 0);
    wait_idle("t drain busy");
    check_eq("t err_cnt", err_cnt, 0);

    // Fill to DEPTH with exc_en=0, fifth bit held until a slot frees
    reset_dut(2'b00);
    fill_bits = 4'b1010;
    tgt_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tgt_bit = fill_bits[i];
      tick();
      check_eq($sformatf("fill ready%0d", i), tgt_ready, (i < 3) ? 1 : 0);
    end
    tgt_bit = 1'b1;
    tick();
    check_eq("fill held ready", tgt_ready, 0);
    exc_en = 1'b1;
    tick();
    check_eq("fill pop0 ready", tgt_ready, 1);
    check_eq("fill pop0 a", exc_a, 1);
    check_eq("fill pop0 b", exc_b, 0);
    tick();
    tgt_valid = 1'b0;
    check_eq("fill pop1 b", exc_b, 1);
    tick();
    check_eq("fill pop2 a", exc_a, 1);
    tick();
    check_eq("fill pop3 b", exc_b, 1);
    tick();
    check_eq("fill pop4 a", exc_a, 1);
    check_eq("fill pop4 b", exc_b, 0);
    tick();
    check_eq("fill idle a", exc_a, 0);
    check_eq("fill idle b", exc_b, 0);

    // D mode with q_fb stuck at 0: one mismatch, then saturate
    reset_dut(2'b11);
    force_zero = 1'b1;
    exc_en = 1'b1;
    tgt_valid = 1'b1; tgt_bit = 1'b1;
    tick();
    tgt_valid = 1'b0;
    tick();
    check_eq("d issue a", exc_a, 1);
    check_eq("d issue b", exc_b, 0);
    repeat (6) tick();
    check_eq("mm pulses 1", mm_pulses, FB_CHK ? 1 : 0);
    check_eq("mm err_cnt 1", err_cnt, FB_CHK ? 1 : 0);
    tgt_valid = 1'b1;
    repeat (259) tick();
    tgt_valid = 1'b0;
    repeat (6) tick();
    check_eq("mm pulses 260", mm_pulses, FB_CHK ? 260 : 0);
    check_eq("mm err_cnt sat", err_cnt, FB_CHK ? 255 : 0);
    wait_idle("mm drain busy");

    // Async reset with 3 entries queued and err_cnt non-zero
    force_zero = 1'b0;
    mode = 2'b00; flop_type = 2'b00;
    exc_en = 1'b0;
    tick();
    tgt_valid = 1'b1;
    tgt_bit = 1'b0; tick();
    tgt_bit = 1'b1; tick();
    tick();
    tick();
    tgt_valid = 1'b0;
    exc_en = 1'b1;
    tick();
    exc_en = 1'b0;
    check_eq("pre-rst b", exc_b, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid-rst tgt_ready", tgt_ready, 1);
    check_eq("mid-rst exc_a", exc_a, 0);
    check_eq("mid-rst exc_b", exc_b, 0);
    check_eq("mid-rst err_cnt", err_cnt, 0);
    check_eq("mid-rst busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exc_en = 1'b1; tgt_valid = 1'b1; tgt_bit = 1'b1;
    tick();
    tgt_valid = 1'b0;
    tick();
    check_eq("post-rst a", exc_a, 1);
    check_eq("post-rst b", exc_b, 0);
    wait_idle("post-rst busy");

    // JK with two entries queued, switch to D while busy
    reset_dut(2'b01);
    tgt_valid = 1'b1;
    tgt_bit = 1'b1; tick();
    tgt_bit = 1'b0; tick();
    tgt_valid = 1'b0;
    mode = 2'b11;
    exc_en = 1'b1;
    tick();
    check_eq("jk pop0 a", exc_a, 1);
    check_eq("jk pop0 b", exc_b, 0);
    tick();
    check_eq("jk pop1 a", exc_a, 0);
    check_eq("jk pop1 b", exc_b, 1);
    wait_idle("jk drain busy");
    tick();
    flop_type = 2'b11;
    tgt_valid = 1'b1; tgt_bit = 1'b1;
    tick();
    tgt_valid = 1'b0;
    tick();
    check_eq("d pop a", exc_a, 1);
    check_eq("d pop b", exc_b, 0);
    tick();
    check_eq("d hold a", exc_a, 1);
    wait_idle("d drain busy");
    check_eq("jk/d no mismatch", mm_pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
